// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-port arbiter bus: ALU/load sources, register-file write port, forwarding lookups
interface wb_arbiter_if;
    logic       alu_valid_i;
    logic [2:0] alu_addr_i;
    logic [7:0] alu_data_i;
    logic       ld_valid_i;
    logic [2:0] ld_addr_i;
    logic [7:0] ld_data_i;
    logic       ld_ready_o;
    logic       wr_en_o;
    logic [2:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic [2:0] fwd_addr_a_i;
    logic [2:0] fwd_addr_b_i;
    logic       fwd_hit_a_o;
    logic       fwd_hit_b_o;
    logic [7:0] fwd_data_a_o;
    logic [7:0] fwd_data_b_o;

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output ld_valid_i, ld_addr_i, ld_data_i,
        input  ld_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o,
        output fwd_addr_a_i, fwd_addr_b_i,
        input  fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o
    );

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  ld_valid_i, ld_addr_i, ld_data_i,
        output ld_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o,
        input  fwd_addr_a_i, fwd_addr_b_i,
        output fwd_hit_a_o, fwd_hit_b_o, fwd_data_a_o, fwd_data_b_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter merging ALU results with buffered loads
// Operand forwarding is built only when WB_ARBITER_FWD_EN is defined.
module wb_arbiter #(
    parameter int LD_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(LD_DEPTH);

    logic          ent_valid [LD_DEPTH];
    logic [2:0]    ent_addr  [LD_DEPTH];
    logic [7:0]    ent_data  [LD_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          alu_win;
    logic          push;
    logic          pop;
    logic          push_valid;

    assign full           = (count == FULL_CNT);
    assign empty          = (count == '0);
    assign bus.ld_ready_o = ~full;
    assign alu_win        = bus.alu_valid_i && (bus.alu_addr_i != 3'd0);
    // r0 loads complete the handshake but never occupy a slot
    assign push           = bus.ld_valid_i && !full && (bus.ld_addr_i != 3'd0);
    assign pop            = !alu_win && !empty;
    assign push_valid     = !(alu_win && (bus.ld_addr_i == bus.alu_addr_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            bus.wr_en_o   <= 1'b0;
            bus.wr_addr_o <= 3'd0;
            bus.wr_data_o <= 8'd0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
            end
        end else begin
            // a winning ALU write is younger than every buffered load to the same register
            for (int i = 0; i < LD_DEPTH; i++) begin
                if (alu_win && (ent_addr[i] == bus.alu_addr_i)) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (push) begin
                ent_valid[wr_ptr] <= push_valid;
                ent_addr[wr_ptr]  <= bus.ld_addr_i;
                ent_data[wr_ptr]  <= bus.ld_data_i;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase

            if (alu_win) begin
                bus.wr_en_o   <= 1'b1;
                bus.wr_addr_o <= bus.alu_addr_i;
                bus.wr_data_o <= bus.alu_data_i;
            end else if (!empty) begin
                bus.wr_en_o   <= ent_valid[rd_ptr];
                bus.wr_addr_o <= ent_addr[rd_ptr];
                bus.wr_data_o <= ent_data[rd_ptr];
            end else begin
                bus.wr_en_o   <= 1'b0;
            end
        end
    end

`ifdef WB_ARBITER_FWD_EN
    logic [2:0] fwd_addr [2];
    logic       fwd_hit  [2];
    logic [7:0] fwd_data [2];

    assign fwd_addr[0] = bus.fwd_addr_a_i;
    assign fwd_addr[1] = bus.fwd_addr_b_i;

    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = 8'd0;
            // scan oldest to youngest so the youngest matching entry wins;
            // slots outside the occupied region are always invalid
            for (int k = 0; k < LD_DEPTH; k++) begin
                idx = rd_ptr + PW'(k);
                if (ent_valid[idx] && (ent_addr[idx] == fwd_addr[p])) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = ent_data[idx];
                end
            end
            if (bus.wr_en_o && (bus.wr_addr_o == fwd_addr[p])) begin
                fwd_hit[p]  = 1'b1;
                fwd_data[p] = bus.wr_data_o;
            end
            if (fwd_addr[p] == 3'd0) begin
                fwd_hit[p]  = 1'b0;
                fwd_data[p] = 8'd0;
            end
        end
    end

    assign bus.fwd_hit_a_o  = fwd_hit[0];
    assign bus.fwd_hit_b_o  = fwd_hit[1];
    assign bus.fwd_data_a_o = fwd_data[0];
    assign bus.fwd_data_b_o = fwd_data[1];
`else
    logic unused_fwd;
    assign unused_fwd       = ^{bus.fwd_addr_a_i, bus.fwd_addr_b_i};
    assign bus.fwd_hit_a_o  = 1'b0;
    assign bus.fwd_hit_b_o  = 1'b0;
    assign bus.fwd_data_a_o = 8'd0;
    assign bus.fwd_data_b_o = 8'd0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter: vector table, corner sequences, random vs queue model
module tb_wb_arbiter;
    localparam int LD_DEPTH = 2;
`ifdef WB_ARBITER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    wb_arbiter_if bus();

    wb_arbiter #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        logic       av;
        logic [2:0] aa;
        logic [7:0] ad;
        logic       lv;
        logic [2:0] la;
        logic [7:0] ld;
        logic       rdy;
        logic       en;
        logic [2:0] wa;
        logic [7:0] wd;
    } vec_t;

    ent_t       mq[$];
    logic       m_en;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] rf [8];
    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] m_fwd(input logic [2:0] a);
        if (!FWD || a == 3'd0) return 9'd0;
        if (m_en && m_addr == a) return {1'b1, m_data};
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].valid && mq[k].addr == a) return {1'b1, mq[k].data};
        end
        return 9'd0;
    endfunction

    function automatic vec_t mk(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                                input logic lv, input logic [2:0] la, input logic [7:0] ld,
                                input logic rdy, input logic en, input logic [2:0] wa, input logic [7:0] wd);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
        v.rdy = rdy; v.en = en; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    // One clock: drive inputs, check combinational outputs, advance the model, check registered outputs.
    task automatic cycle(input logic rst, input logic av, input logic [2:0] aa, input logic [7:0] ad,
                         input logic lv, input logic [2:0] la, input logic [7:0] ld,
                         input logic [2:0] fa, input logic [2:0] fb,
                         output logic rdy_seen, output logic hit_a_seen, output logic [7:0] data_a_seen);
        logic [8:0] fx;
        logic       alu_win;
        logic       accept;
        logic       had;
        ent_t       h;
        rst_i = rst;
        bus.alu_valid_i = av; bus.alu_addr_i = aa; bus.alu_data_i = ad;
        bus.ld_valid_i  = lv; bus.ld_addr_i  = la; bus.ld_data_i  = ld;
        bus.fwd_addr_a_i = fa; bus.fwd_addr_b_i = fb;
        #1;
        rdy_seen    = bus.ld_ready_o;
        hit_a_seen  = bus.fwd_hit_a_o;
        data_a_seen = bus.fwd_data_a_o;
        check("ld_ready", {31'd0, bus.ld_ready_o}, {31'd0, mq.size() < LD_DEPTH});
        fx = m_fwd(fa);
        check("fwd_a", {23'd0, bus.fwd_hit_a_o, bus.fwd_data_a_o}, {23'd0, fx});
        fx = m_fwd(fb);
        check("fwd_b", {23'd0, bus.fwd_hit_b_o, bus.fwd_data_b_o}, {23'd0, fx});

        if (rst) begin
            mq.delete();
            m_en = 1'b0; m_addr = 3'd0; m_data = 8'd0;
        end else begin
            alu_win = av && aa != 3'd0;
            accept  = lv && mq.size() < LD_DEPTH;
            had     = mq.size() > 0;
            if (alu_win) begin
                foreach (mq[k]) if (mq[k].addr == aa) mq[k].valid = 1'b0;
                m_en = 1'b1; m_addr = aa; m_data = ad;
            end else if (had) begin
                h = mq.pop_front();
                m_en = h.valid; m_addr = h.addr; m_data = h.data;
            end else begin
                m_en = 1'b0;
            end
            if (accept && la != 3'd0) mq.push_back({!(alu_win && la == aa), la, ld});
        end

        @(posedge clk_i);
        #1;
        check("wr_port", {20'd0, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o}, {20'd0, m_en, m_addr, m_data});
        check("no_r0_write", {31'd0, bus.wr_en_o && bus.wr_addr_o == 3'd0}, 32'd0);
        if (bus.wr_en_o === 1'b1) rf[bus.wr_addr_o] = bus.wr_data_o;
    endtask

    task automatic idle(output logic rdy, output logic ha, output logic [7:0] da);
        cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 3'd0, 3'd0, rdy, ha, da);
    endtask

    vec_t       vt [20];
    logic       rdy;
    logic       ha;
    logic [7:0] da;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'd0;
        rst_i = 1'b1;
        bus.alu_valid_i = 1'b0; bus.alu_addr_i = 3'd0; bus.alu_data_i = 8'd0;
        bus.ld_valid_i  = 1'b0; bus.ld_addr_i  = 3'd0; bus.ld_data_i  = 8'd0;
        bus.fwd_addr_a_i = 3'd0; bus.fwd_addr_b_i = 3'd0;
        repeat (2) @(posedge clk_i);
        #1;
        mq.delete(); m_en = 1'b0; m_addr = 3'd0; m_data = 8'd0;
        check("reset_ready", {31'd0, bus.ld_ready_o}, 32'd1);
        check("reset_wr", {20'd0, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o}, 32'd0);
        check("reset_fwd", {30'd0, bus.fwd_hit_a_o, bus.fwd_hit_b_o}, 32'd0);

        vt[0]  = mk(0, 0, 8'h00, 1, 3, 8'h5A, 1, 0, 0, 8'h00);
        vt[1]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 3, 8'h5A);
        vt[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 3, 8'h5A);
        vt[3]  = mk(1, 0, 8'hFF, 1, 7, 8'h33, 1, 0, 3, 8'h5A);
        vt[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 7, 8'h33);
        vt[5]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 7, 8'h33);
        vt[6]  = mk(0, 0, 8'h00, 1, 1, 8'hAA, 1, 0, 7, 8'h33);
        vt[7]  = mk(1, 1, 8'h01, 0, 0, 8'h00, 1, 1, 1, 8'h01);
        vt[8]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'hAA);
        vt[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'hAA);
        vt[10] = mk(0, 0, 8'h00, 1, 0, 8'h77, 1, 0, 1, 8'hAA);
        vt[11] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 8'hAA);
        vt[12] = mk(1, 2, 8'h11, 1, 4, 8'h44, 1, 1, 2, 8'h11);
        vt[13] = mk(1, 2, 8'h11, 1, 5, 8'h55, 1, 1, 2, 8'h11);
        vt[14] = mk(1, 2, 8'h11, 1, 6, 8'h66, 0, 1, 2, 8'h11);
        vt[15] = mk(1, 2, 8'h11, 1, 6, 8'h66, 0, 1, 2, 8'h11);
        vt[16] = mk(0, 0, 8'h00, 1, 6, 8'h66, 0, 1, 4, 8'h44);
        vt[17] = mk(0, 0, 8'h00, 1, 6, 8'h66, 1, 1, 5, 8'h55);
        vt[18] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 6, 8'h66);
        vt[19] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 6, 8'h66);

        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, vt[i].av, vt[i].aa, vt[i].ad, vt[i].lv, vt[i].la, vt[i].ld, 3'd0, 3'd0, rdy, ha, da);
            check($sformatf("vec%0d_ready", i), {31'd0, rdy}, {31'd0, vt[i].rdy});
            check($sformatf("vec%0d_wr", i), {20'd0, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o},
                  {20'd0, vt[i].en, vt[i].wa, vt[i].wd});
        end
        check("r1_final", {24'd0, rf[1]}, 32'h01);
        check("r0_untouched", {24'd0, rf[0]}, 32'h00);

        // reset while two loads sit in the buffer
        cycle(1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd5, 8'h55, 3'd0, 3'd0, rdy, ha, da);
        cycle(1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd6, 8'h66, 3'd0, 3'd0, rdy, ha, da);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, rdy, ha, da);
        check("rst_full_before", {31'd0, rdy}, 32'd0);
        check("rst_ready_after", {31'd0, bus.ld_ready_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(rdy, ha, da);
            check("rst_no_drain", {31'd0, bus.wr_en_o}, 32'd0);
        end

        // forwarding of a pending load, then from the write stage
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h42, 3'd0, 3'd0, rdy, ha, da);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd3, 3'd0, rdy, ha, da);
        check("fwd_buf_hit", {23'd0, ha, da}, FWD ? 32'h142 : 32'h0);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd3, rdy, ha, da);
        check("fwd_addr0_miss", {23'd0, ha, da}, 32'h0);
        check("fwd_wr_stage", {23'd0, bus.fwd_hit_b_o, bus.fwd_data_b_o}, {23'd0, m_fwd(3'd3)});

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rdy, ha, da);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-side driver for the 8-bit CPU register file. It owns the single write port: wr_en_o, wr_addr_o and wr_data_o connect to the register file's write enable, write address and write data.
- It merges two result sources:
  - ALU results: single-cycle and never stallable.
  - Load results: multi-cycle, with a valid/ready handshake.
- A small load buffer resolves write-port collisions. The block optionally forwards pending values to the operand-read stage.

Parameters:
- LD_DEPTH, 2: number of load-buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  clock. All state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- alu_valid_i  input  1  ALU result present this cycle.
- alu_addr_i  input  3  ALU destination register.
- alu_data_i  input  8  ALU result.
- ld_valid_i  input  1  load result offered.
- ld_addr_i  input  3  load destination register.
- ld_data_i  input  8  load data.
- ld_ready_o  output  1  load buffer can accept a result.
- wr_en_o  output  1  register-file write enable (registered).
- wr_addr_o  output  3  register-file write address (registered).
- wr_data_o  output  8  register-file write data (registered).
- fwd_addr_a_i  input  3  operand A lookup address.
- fwd_addr_b_i  input  3  operand B lookup address.
- fwd_hit_a_o  output  1  operand A has a pending write.
- fwd_hit_b_o  output  1  operand B has a pending write.
- fwd_data_a_o  output  8  forwarded operand A value.
- fwd_data_b_o  output  8  forwarded operand B value.

Behaviour:
- Reset: when rst_i=1 at a rising edge:
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0.
  - Load buffer empties; all entries invalid.
  - ld_ready_o=1 and fwd_hit_*=0 in the following cycle.
  - Inputs are ignored during reset. Reset mid-drain discards buffered loads.
- Load handshake:
  - A load is accepted at an edge when ld_valid_i & ld_ready_o.
  - ld_ready_o = ~full. It depends only on the current count, not on a same-cycle pop.
  - Accepted loads with ld_addr_i=0 are consumed and discarded; they are never enqueued.
- Buffer: circular FIFO with read/write pointers of log2(LD_DEPTH) bits (wrap-around) and a count of log2(LD_DEPTH)+1 bits. Each entry holds valid, addr[2:0] and data[7:0].
- Port selection at each rising edge (priority order):
  1. If alu_valid_i and alu_addr_i!=0: register {1, alu_addr_i, alu_data_i}.
  2. Else, if the FIFO is non-empty: pop the head. Register {head.valid, head.addr, head.data}; a squashed head pops with wr_en_o=0.
  3. Else: wr_en_o=0. wr_addr_o and wr_data_o hold their previous values.
- Latency:
  - ALU result: wr_en_o is high in the cycle after presentation.
  - Load: wr_en_o is high at the earliest two cycles after acceptance, because an enqueue and a pop of the same entry cannot occur at the same edge.
- Simultaneous push and pop at the same edge: allowed whenever not full. Count is unchanged.
- Ordering rule: an ALU result is always program-younger than any load accepted at the same or an earlier edge.
  - When the ALU wins with address X, every buffered entry with addr==X is cleared to valid=0 at that edge (squash).
  - A load accepted at that same edge with address X is enqueued already invalid.
  - Squashed entries still occupy slots until popped.
- Register 0 is never written: wr_en_o is never 1 with wr_addr_o=0.

Optional Feature:
- Macro: WB_ARBITER_FWD_EN.
- Defined: fwd_hit_a_o and fwd_data_a_o are combinational from fwd_addr_a_i; operand B is identical using fwd_addr_b_i.
  - Lookup address 0 never hits.
  - Highest priority: the registered write stage, i.e. wr_en_o & wr_addr_o==addr returns wr_data_o.
  - Next: the youngest valid FIFO entry with a matching address returns its data.
  - Otherwise: hit=0, data=0.
- Undefined: fwd_hit_*=0 and fwd_data_*=0 (constant). The buffer and write-port behaviour are unchanged.

Test Plan:
- After reset, ld_valid_i=1, addr=3, data=0x5A, no ALU activity → accepted. Two cycles later, wr_en_o=1, wr_addr_o=3, wr_data_o=0x5A; then wr_en_o=0.
- ALU writes r2 with 0x11 on 4 consecutive cycles while loads to r4, r5 and r6 are offered → ld_ready_o drops after 2 accepts. r4 and r5 then drain in the two cycles after the ALU stops; r6 is accepted once the buffer is no longer full and written after them.
- Load r1=0xAA is buffered, then the ALU writes r1=0x01 → wr_data_o=0x01. The r1 slot later pops with wr_en_o=0, and r1 ends at 0x01.
- ALU addr=0 data=0xFF together with a load to r7 of 0x33 → no write to r0. r7=0x33 is written two cycles later.
- Load r3=0x42 is pending and fwd_addr_a_i=3 (macro defined) → fwd_hit_a_o=1, fwd_data_a_o=0x42. With fwd_addr_a_i=0 → fwd_hit_a_o=0.
- Assert rst_i while 2 loads are buffered → next cycle ld_ready_o=1 and wr_en_o stays 0. No buffered write ever appears.
